multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Moore-style control FSM for the multicycle RV32I core. It sequences instruction fetch, decode, execute, memory and writeback, and drives the immediate-extender format select (IMMSrc) plus all datapath enables and muxes. Memory accesses stall on a ready handshake. Unsupported opcodes park the FSM in a sticky trap state.

Parameters:
RESET_STATE, FETCH, initial state entered on reset (kept for bring-up/debug).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
op  input  7  instr[6:0] from IR
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
branch_taken  input  1  comparator result for the current B-type instruction
mem_ready  input  1  memory has completed the current read/write this cycle
IMMSrc  output  3  extender format: 000 I, 001 S, 010 B, 011 U, 100 J
PCWrite  output  1  PC register enable
IRWrite  output  1  IR and OldPC enable
AdrSrc  output  1  memory address: 0 PC, 1 ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
RegWrite  output  1  register-file write enable
ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1
ALUSrcB  output  2  00 rs2, 01 ImmOp, 10 constant 4
ALUOp  output  2  00 add, 01 sub/compare, 10 funct-decoded
illegal  output  1  sticky illegal-instruction flag
state_dbg  output  4  current state encoding

Behaviour:
- Reset (async, rst=1) forces state=FETCH immediately. All enables (PCWrite, IRWrite, MemRead, MemWrite, RegWrite) and illegal are 0. All selects are 0. Releasing rst mid-instruction always restarts at FETCH.
- Outputs are a function of state only, except PCWrite, IRWrite and PCWrite-on-branch, which are qualified by inputs as listed below.
- Selects default to 00 and enables default to 0 in every state unless listed.
- FETCH: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. PCWrite and IRWrite both equal mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, IMMSrc=010 (precomputes the branch target). Next state by op:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other op -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. IMMSrc=000 for loads, 001 for stores. Next state MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: MemRead=1, AdrSrc=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: RegWrite=1, ResultSrc=01, then FETCH.
- MEMWRITE: MemWrite=1, AdrSrc=1. Hold until mem_ready=1, then FETCH. MemWrite stays asserted and stable for every stall cycle.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, IMMSrc=000, then ALUWB.
- ALUWB: RegWrite=1, ResultSrc=00, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, IMMSrc=010. PCWrite=branch_taken. Then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, IMMSrc=100, then ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, IMMSrc=000, ALUOp=00. Then JALR_LINK, which has ALUSrcA=01, ALUSrcB=10, PCWrite=1, ResultSrc=00, then ALUWB.
  - In the JALR state itself, ResultSrc=10 and the PC target is captured via ALUOut.
- LUI: IMMSrc=011, ALUSrcB=01, ALUOp=00, ALUSrcA=10 with rs1 forced x0 by the datapath; then ALUWB.
- AUIPC: IMMSrc=011, ALUSrcA=01, ALUSrcB=01, ALUOp=00, then ALUWB.
- TRAP: all enables 0, illegal=1. Stays in TRAP until rst. An instruction is never partially committed.
- IMMSrc is never driven above 100 in any state.
- funct3 and funct7b5 feed ALUOp=10 decode only; they do not affect sequencing.
- Latency with mem_ready tied 1:
  - R/I-ALU, LUI, AUIPC: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - JAL: 4 cycles
  - JALR: 5 cycles

Test Plan:
- Reset, then add (op=0110011) with mem_ready=1: state sequence FETCH, DECODE, EXECR, ALUWB, FETCH. RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
- lw (op=0000011) with mem_ready low for 3 cycles in MEMREAD: MemRead held for 4 cycles. IMMSrc=000 in MEMADR. RegWrite=1 exactly once with ResultSrc=01.
- sw (op=0100011): IMMSrc=001 in MEMADR. MemWrite=1 until mem_ready; RegWrite never asserted.
- beq (op=1100011) with branch_taken=1, then repeated with branch_taken=0: PCWrite=1 in BRANCH for the first, 0 for the second. IMMSrc=010 in DECODE and BRANCH.
- jal (op=1101111), then lui (op=0110111): IMMSrc=100 in JAL with PCWrite=1. IMMSrc=011 in LUI. Each ends with one RegWrite pulse.
- Illegal op=1111111: FETCH, DECODE, TRAP. illegal=1 stays set for 10 further cycles. Asserting rst mid-MEMREAD returns to FETCH with all enables 0 in the same cycle.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for the multicycle RV32I datapath: drives enables/selects per state,
// stalls FETCH/MEMREAD/MEMWRITE on mem_ready, parks unsupported opcodes in a sticky TRAP state.
module multicycle_control_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic [2:0] IMMSrc,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECR     = 4'd6,
    S_EXECI     = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR      = 4'd11,
    S_JALR_LINK = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] A_PC    = 2'b00;
  localparam logic [1:0] A_OLDPC = 2'b01;
  localparam logic [1:0] A_RS1   = 2'b10;

  localparam logic [1:0] B_RS2   = 2'b00;
  localparam logic [1:0] B_IMM   = 2'b01;
  localparam logic [1:0] B_FOUR  = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  state_t state_q, state_d;

  // funct fields are consumed by the ALU decoder, never by sequencing.
  logic unused_funct;
  assign unused_funct = ^{funct3, funct7b5};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= state_t'(RESET_STATE);
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    IMMSrc    = IMM_I;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = A_PC;
    ALUSrcB   = B_RS2;
    ALUOp     = ALU_ADD;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcA   = A_PC;
        ALUSrcB   = B_FOUR;
        ResultSrc = RES_ALURES;
        PCWrite   = mem_ready;
        IRWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH can use the ALU for the compare.
        ALUSrcA = A_OLDPC;
        ALUSrcB = B_IMM;
        IMMSrc  = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = A_RS1;
        ALUSrcB = B_IMM;
        IMMSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
        state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_DATA;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = A_RS1;
        ALUSrcB = B_RS2;
        ALUOp   = ALU_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = A_RS1;
        ALUSrcB = B_IMM;
        ALUOp   = ALU_FUNCT;
        IMMSrc  = IMM_I;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        ResultSrc = RES_ALUOUT;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = A_RS1;
        ALUSrcB   = B_RS2;
        ALUOp     = ALU_SUB;
        ResultSrc = RES_ALUOUT;
        IMMSrc    = IMM_B;
        PCWrite   = branch_taken;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = A_OLDPC;
        ALUSrcB   = B_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
        IMMSrc    = IMM_J;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        // Target rs1+imm lands in ALUOut; the link value is formed next cycle.
        ALUSrcA   = A_RS1;
        ALUSrcB   = B_IMM;
        IMMSrc    = IMM_I;
        ResultSrc = RES_ALURES;
        state_d   = S_JALR_LINK;
      end
      S_JALR_LINK: begin
        ALUSrcA   = A_OLDPC;
        ALUSrcB   = B_FOUR;
        ResultSrc = RES_ALUOUT;
        PCWrite   = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = A_RS1;
        ALUSrcB = B_IMM;
        IMMSrc  = IMM_U;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = A_OLDPC;
        ALUSrcB = B_IMM;
        IMMSrc  = IMM_U;
        state_d = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase

    // Outputs are forced quiet for the whole reset interval, including mid-cycle assertion.
    if (rst) begin
      IMMSrc    = IMM_I;
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = A_PC;
      ALUSrcB   = B_RS2;
      ALUOp     = ALU_ADD;
      illegal   = 1'b0;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: step-list model checked every cycle plus per-instruction literal counts.
module tb_multicycle_control_fsm;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, branch_taken, mem_ready;
  logic [2:0] IMMSrc;
  logic       PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       illegal;
  logic [3:0] state_dbg;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .IMMSrc(IMMSrc), .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  // Model steps: each instruction is FETCH, DECODE, then a per-opcode list of steps.
  localparam int F = 0, D = 1, MAL = 2, MAS = 3, MR = 4, MWB = 5, MW = 6, XR = 7, XI = 8;
  localparam int WB = 9, BR = 10, JL = 11, JR = 12, JRL = 13, LU = 14, AU = 15, TR = 16;

  // Vector layout: {IMMSrc, PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
  //                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal}
  logic [17:0] tab [0:16];
  int cur = F;
  int plan[$];
  bit chk_en = 1'b0;

  function automatic logic [17:0] mk(input logic [2:0] imm, input logic pcw, irw, adr, mrd, mwr, rgw,
                                     input logic [1:0] res, sa, sb, ao, input logic ill);
    return {imm, pcw, irw, adr, mrd, mwr, rgw, res, sa, sb, ao, ill};
  endfunction

  initial begin
    //            imm    pcw irw adr mrd mwr rgw res    srcA   srcB   aluop  ill
    tab[F]   = mk(3'b000, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    tab[D]   = mk(3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
    tab[MAL] = mk(3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
    tab[MAS] = mk(3'b001, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
    tab[MR]  = mk(3'b000, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    tab[MWB] = mk(3'b000, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
    tab[MW]  = mk(3'b000, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    tab[XR]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
    tab[XI]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0);
    tab[WB]  = mk(3'b000, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    tab[BR]  = mk(3'b010, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0);
    tab[JL]  = mk(3'b100, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);
    tab[JR]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 2'b00, 0);
    tab[JRL] = mk(3'b000, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);
    tab[LU]  = mk(3'b011, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
    tab[AU]  = mk(3'b011, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0);
    tab[TR]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
  end

  function automatic void route(input logic [6:0] o);
    int s[3];
    s = '{-1, -1, -1};
    case (o)
      7'b0000011: s = '{MAL, MR, MWB};
      7'b0100011: s = '{MAS, MW, -1};
      7'b0110011: s = '{XR, WB, -1};
      7'b0010011: s = '{XI, WB, -1};
      7'b1100011: s = '{BR, -1, -1};
      7'b1101111: s = '{JL, WB, -1};
      7'b1100111: s = '{JR, JRL, WB};
      7'b0110111: s = '{LU, WB, -1};
      7'b0010111: s = '{AU, WB, -1};
      default:    s = '{TR, -1, -1};
    endcase
    plan.delete();
    foreach (s[i]) if (s[i] >= 0) plan.push_back(s[i]);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  // Model advance: inputs seen here are the ones held through the cycle just ending.
  always @(posedge clk) begin
    if (rst) begin
      cur = F;
      plan.delete();
    end else if (cur == TR) begin
      cur = TR;
    end else if ((cur == F || cur == MR || cur == MW) && !mem_ready) begin
      cur = cur;
    end else if (cur == F) begin
      cur = D;
    end else if (cur == D) begin
      route(op);
      cur = plan.pop_front();
    end else if (plan.size() > 0) begin
      cur = plan.pop_front();
    end else begin
      cur = F;
    end
  end

  always @(negedge clk) begin : cmp
    logic [17:0] e, a;
    if (chk_en) begin
      e = rst ? 18'd0 : tab[cur];
      if (!rst && cur == F) begin
        e[14] = mem_ready;
        e[13] = mem_ready;
      end
      if (!rst && cur == BR) e[14] = branch_taken;
      a = {IMMSrc, PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal};
      check($sformatf("ctrl_step%0d", cur), 32'(a), 32'(e));
    end
  end

  // Runs one instruction from its FETCH cycle for ncyc cycles; mem_ready low for [stall_at, stall_at+stall_len).
  task automatic run_instr(input string nm, input logic [6:0] opc, input logic bt,
                           input int stall_at, input int stall_len, input int ncyc,
                           input int e_rw, input int e_pcw, input int e_mrd, input int e_mwr, input int e_ill);
    int rw, pcw, mrd, mwr, ill;
    rw = 0; pcw = 0; mrd = 0; mwr = 0; ill = 0;
    for (int c = 0; c < ncyc; c++) begin
      op           = opc;
      branch_taken = bt;
      funct3       = 3'($urandom_range(0, 7));
      funct7b5     = 1'($urandom_range(0, 1));
      mem_ready    = !(c >= stall_at && c < stall_at + stall_len);
      @(negedge clk);
      if (c == 0) check({nm, "_fetch_start"}, {30'd0, MemRead, AdrSrc}, 32'b10);
      rw  += int'(RegWrite);
      pcw += int'(PCWrite);
      mrd += int'(MemRead);
      mwr += int'(MemWrite);
      ill += int'(illegal);
      @(posedge clk);
      #1;
    end
    check({nm, "_regwrite_cnt"}, rw, e_rw);
    check({nm, "_pcwrite_cnt"}, pcw, e_pcw);
    check({nm, "_memread_cnt"}, mrd, e_mrd);
    check({nm, "_memwrite_cnt"}, mwr, e_mwr);
    check({nm, "_illegal_cnt"}, ill, e_ill);
  endtask

  initial begin
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    branch_taken = 1'b0; mem_ready = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_outs", {18'd0, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal,
                         IMMSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    //        name      op          bt  st  len cyc rw pcw mrd mwr ill
    run_instr("add",    7'b0110011, 0, 0,  0,  4,  1, 1,  1,  0,  0);
    run_instr("addi",   7'b0010011, 0, 0,  2,  6,  1, 1,  3,  0,  0);
    run_instr("lw",     7'b0000011, 0, 3,  3,  8,  1, 1,  5,  0,  0);
    run_instr("sw",     7'b0100011, 0, 3,  2,  6,  0, 1,  1,  3,  0);
    run_instr("beq_t",  7'b1100011, 1, 0,  0,  3,  0, 2,  1,  0,  0);
    run_instr("beq_nt", 7'b1100011, 0, 0,  0,  3,  0, 1,  1,  0,  0);
    run_instr("jal",    7'b1101111, 0, 0,  0,  4,  1, 2,  1,  0,  0);
    run_instr("lui",    7'b0110111, 0, 0,  0,  4,  1, 1,  1,  0,  0);
    run_instr("jalr",   7'b1100111, 0, 0,  0,  5,  1, 2,  1,  0,  0);
    run_instr("auipc",  7'b0010111, 0, 0,  0,  4,  1, 1,  1,  0,  0);

    // Load that never gets mem_ready, then reset asserted mid-cycle while in MEMREAD.
    for (int c = 0; c < 5; c++) begin
      op = 7'b0000011;
      mem_ready = (c == 0);
      @(negedge clk);
      if (c == 4) check("in_memread", {30'd0, MemRead, AdrSrc}, 32'b11);
      if (c < 4) begin
        @(posedge clk); #1;
      end
    end
    #2 rst = 1'b1;
    #1;
    check("rst_mid_memread", {26'd0, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, AdrSrc}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr("add2",   7'b0110011, 0, 0,  0,  4,  1, 1,  1,  0,  0);

    // FETCH, DECODE, TRAP plus ten more cycles stuck with illegal set.
    run_instr("illegal", 7'b1111111, 0, 0, 0, 13, 0, 1, 1, 0, 11);
    @(negedge clk);
    check("trap_sticky", {31'd0, illegal}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("trap_cleared", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_trap_fetch", {30'd0, MemRead, AdrSrc}, 32'b10);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got run still active required finish by 20000");
    $fatal(1, "timeout");
  end
endmodule
